// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C sequencer: expands byte commands into START/data/ACK/STOP bit commands.
// Optional feature macro I2C_NACK_AUTOSTOP_EN: a NACKed write byte is followed by an automatic STOP.
module i2c_byte_sequencer (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic [2:0] bit_cmd,
  output logic       bit_txd,
  input  logic       bit_cmd_ack,
  input  logic       bit_rxd,
  input  logic       bit_al
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WRITE,
    S_READ,
    S_ACK,
    S_STOP
  } state_t;

  state_t     state;
  logic [7:0] shift;
  logic [2:0] cnt;
  logic       byte_is_read;
  logic       go_stop;

`ifdef I2C_NACK_AUTOSTOP_EN
  assign go_stop = stop | (~byte_is_read & bit_rxd);
`else
  assign go_stop = stop;
`endif

  assign dout   = shift;
  assign i2c_al = bit_al;

  // Loss of enable or arbitration abandons the byte but keeps the data registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state        <= S_IDLE;
      bit_cmd      <= CMD_NOP;
      bit_txd      <= 1'b0;
      cmd_ack      <= 1'b0;
      ack_out      <= 1'b0;
      shift        <= 8'h00;
      cnt          <= 3'd0;
      byte_is_read <= 1'b0;
    end else if (!ena || bit_al) begin
      state   <= S_IDLE;
      bit_cmd <= CMD_NOP;
      cmd_ack <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((start | stop | read | write) && !cmd_ack) begin
            cnt          <= 3'd7;
            byte_is_read <= read;
            // A stop-only command carries no byte, so the shift register keeps its contents.
            if (start | read | write) shift <= din;
            if (start) begin
              state   <= S_START;
              bit_cmd <= CMD_START;
            end else if (read) begin
              state   <= S_READ;
              bit_cmd <= CMD_READ;
            end else if (write) begin
              state   <= S_WRITE;
              bit_cmd <= CMD_WRITE;
              bit_txd <= din[7];
            end else begin
              state   <= S_STOP;
              bit_cmd <= CMD_STOP;
            end
          end
        end
        S_START: begin
          if (bit_cmd_ack) begin
            if (read) begin
              state        <= S_READ;
              bit_cmd      <= CMD_READ;
              byte_is_read <= 1'b1;
            end else begin
              state        <= S_WRITE;
              bit_cmd      <= CMD_WRITE;
              bit_txd      <= shift[7];
              byte_is_read <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (bit_cmd_ack) begin
            shift <= {shift[6:0], 1'b0};
            cnt   <= cnt - 3'd1;
            if (cnt == 3'd0) begin
              state   <= S_ACK;
              bit_cmd <= CMD_READ;
              bit_txd <= 1'b0;
            end else begin
              bit_txd <= shift[6];
            end
          end
        end
        S_READ: begin
          if (bit_cmd_ack) begin
            shift <= {shift[6:0], bit_rxd};
            cnt   <= cnt - 3'd1;
            if (cnt == 3'd0) begin
              state   <= S_ACK;
              bit_cmd <= CMD_WRITE;
              bit_txd <= ack_in;
            end
          end
        end
        S_ACK: begin
          if (bit_cmd_ack) begin
            if (!byte_is_read) ack_out <= bit_rxd;
            if (go_stop) begin
              state   <= S_STOP;
              bit_cmd <= CMD_STOP;
            end else begin
              state   <= S_IDLE;
              bit_cmd <= CMD_NOP;
              cmd_ack <= 1'b1;
            end
          end
        end
        S_STOP: begin
          if (bit_cmd_ack) begin
            state   <= S_IDLE;
            bit_cmd <= CMD_NOP;
            cmd_ack <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          bit_cmd <= CMD_NOP;
        end
      endcase
    end
  end

endmodule
